// File: rtl/billiard_pkg.sv
// Shared billiard types and constants: ball count, hole ids, pocket FSM states.
// Pure declarations; no latency and no backpressure.
package billiard_pkg;

    localparam int NUM_BALLS = 2;
    localparam int HOLE_ID_W = 3;
    localparam logic [HOLE_ID_W-1:0] NO_HOLE = 3'd0;
    localparam int OVL_CNT_W = 6;

    typedef enum logic [1:0] {
        S_TRACK,
        S_EVAL,
        S_RERACK,
        S_HOLDOFF
    } pocket_state_t;

endpackage

// File: rtl/ball_pocket_tracker_if.sv
// Pixel/frame inputs and pocket outputs between the VGA draw path and the game controller.
// Plain wires; the master drives the pocket outputs; no backpressure.
interface ball_pocket_tracker_if #(
    parameter int NB = billiard_pkg::NUM_BALLS
) ();
    import billiard_pkg::*;

    logic                 startOfFrame;
    logic [NB:0]          ball_draw;
    logic                 hole_draw;
    logic [HOLE_ID_W-1:0] hole_id;
    logic [3:0]           stage_num;
    logic [HOLE_ID_W-1:0] request_hole;
    logic [NB:0]          balls_in_game;
    logic [NB:0]          ballhole_collide;
    logic [HOLE_ID_W-1:0] curr_Hole_id;

    modport master (
        input  startOfFrame, ball_draw, hole_draw, hole_id, stage_num, request_hole,
        output balls_in_game, ballhole_collide, curr_Hole_id
    );

    modport slave (
        output startOfFrame, ball_draw, hole_draw, hole_id, stage_num, request_hole,
        input  balls_in_game, ballhole_collide, curr_Hole_id
    );
endinterface

// File: rtl/pocket_overlap_counter.sv
// Per-ball saturating overlap counter with latch of the last hole touched.
// Count visible one cycle after inc; clear wins over inc; no backpressure.
module pocket_overlap_counter
    import billiard_pkg::*;
#(
    parameter int POCKET_PIXELS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [HOLE_ID_W-1:0] holeIn,
    output logic                 atThresh,
    output logic [HOLE_ID_W-1:0] holeOut
);

    logic [OVL_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            holeOut <= NO_HOLE;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            if (count != '1) count <= count + 1'b1;
            holeOut <= holeIn;
        end
    end

    assign atThresh = (int'(count) >= POCKET_PIXELS);

endmodule

// File: rtl/ball_pocket_tracker.sv
// Accumulates ball/hole overlap per frame and pocket-evaluates at startOfFrame (pulse 2 cycles after).
// No backpressure; frame paced. POCKET_HOLE_FILTER_EN restricts object balls to request_hole.
module ball_pocket_tracker #(
    parameter int NUM_BALLS           = billiard_pkg::NUM_BALLS,
    parameter int POCKET_PIXELS       = 16,
    parameter int HOLDOFF_FRAMES      = 4,
    parameter int WHITE_RESPOT_FRAMES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    ball_pocket_tracker_if.master bus
);
    import billiard_pkg::*;

    localparam int HW = $clog2(HOLDOFF_FRAMES + 1);

    pocket_state_t        state, nextState;
    logic [3:0]           lastStage;
    logic [HW-1:0]        holdCnt;
    logic [1:0]           respotCnt;
    logic [NUM_BALLS:0]   inGame, collide, qualify, incEn, atThresh, pocketSet;
    logic [HOLE_ID_W-1:0] ballHole [NUM_BALLS+1];
    logic [HOLE_ID_W-1:0] currHole, firstHole;
    logic                 stageChange, cntClear, objQualify;

`ifdef POCKET_HOLE_FILTER_EN
    assign objQualify = (bus.request_hole == NO_HOLE) || (bus.hole_id == bus.request_hole);
`else
    // Target hole only matters when filtering is built in.
    logic unusedReqHole;
    assign objQualify    = 1'b1;
    assign unusedReqHole = ^bus.request_hole;
`endif

    assign qualify     = {{NUM_BALLS{objQualify}}, 1'b1};
    assign stageChange = (bus.stage_num != lastStage);
    assign cntClear    = (state == S_EVAL) || (state == S_RERACK);
    assign incEn       = {(NUM_BALLS+1){(state == S_TRACK) && bus.hole_draw}}
                         & inGame & bus.ball_draw & qualify;
    assign pocketSet   = inGame & atThresh;

    for (genvar g = 0; g <= NUM_BALLS; g++) begin : gBall
        pocket_overlap_counter #(.POCKET_PIXELS(POCKET_PIXELS)) uCnt (
            .clk     (clk),
            .reset   (reset),
            .clear   (cntClear),
            .inc     (incEn[g]),
            .holeIn  (bus.hole_id),
            .atThresh(atThresh[g]),
            .holeOut (ballHole[g])
        );
    end

    // Descending scan leaves the lowest-index pocketed ball's hole.
    always_comb begin
        firstHole = NO_HOLE;
        for (int i = NUM_BALLS; i >= 0; i--) begin
            if (pocketSet[i]) firstHole = ballHole[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_TRACK;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (stageChange && state != S_RERACK) begin
            nextState = S_RERACK;
        end else begin
            case (state)
                S_TRACK:   if (bus.startOfFrame) nextState = S_EVAL;
                S_EVAL:    nextState = S_TRACK;
                S_RERACK:  nextState = S_HOLDOFF;
                S_HOLDOFF: if (bus.startOfFrame && holdCnt <= HW'(1)) nextState = S_TRACK;
                default:   nextState = S_TRACK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inGame    <= '1;
            collide   <= '0;
            currHole  <= NO_HOLE;
            lastStage <= '0;
            holdCnt   <= '0;
            respotCnt <= '0;
        end else begin
            collide <= '0;
            if (state == S_RERACK) begin
                inGame    <= '1;
                respotCnt <= '0;
                lastStage <= bus.stage_num;
                holdCnt   <= HW'(HOLDOFF_FRAMES);
            end else if (nextState != S_RERACK) begin
                if (state == S_EVAL) begin
                    collide <= pocketSet;
                    inGame  <= inGame & ~pocketSet;
                    if (pocketSet != '0) currHole  <= firstHole;
                    if (pocketSet[0])    respotCnt <= 2'(WHITE_RESPOT_FRAMES);
                end else if (!inGame[0] && bus.startOfFrame) begin
                    if (respotCnt <= 2'd1) begin
                        respotCnt <= '0;
                        inGame[0] <= 1'b1;
                    end else begin
                        respotCnt <= respotCnt - 2'd1;
                    end
                end
                if (state == S_HOLDOFF && bus.startOfFrame && holdCnt != '0)
                    holdCnt <= holdCnt - 1'b1;
            end
        end
    end

    assign bus.balls_in_game    = inGame;
    assign bus.ballhole_collide = collide;
    assign bus.curr_Hole_id     = currHole;

endmodule

// File: tb/tb_ball_pocket_tracker.sv
// Scoreboard bench for ball_pocket_tracker: expected pocket pulses queued at frame end, matched by a monitor.
module tb_ball_pocket_tracker;
    import billiard_pkg::*;

    typedef struct {
        logic [2:0] col;
        logic [2:0] balls;
        logic [2:0] hole;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cycNum = 0;
    bit   monOn = 1'b0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycNum++;

    ball_pocket_tracker_if bif ();

    ball_pocket_tracker dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.master)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drawPixels(input int ball, input int n, input logic [2:0] hid);
        for (int i = 0; i < n; i++) begin
            bif.ball_draw = 3'(1 << ball);
            bif.hole_draw = 1'b1;
            bif.hole_id   = hid;
            cyc(1);
        end
        bif.ball_draw = '0;
        bif.hole_draw = 1'b0;
        bif.hole_id   = '0;
        cyc(1);
    endtask

    // Ends the frame; balls/hole are the expected outputs once the frame has been evaluated.
    task automatic endFrame(input bit pulse, input logic [2:0] col, input logic [2:0] balls,
                            input logic [2:0] hole);
        exp_t e;
        bif.startOfFrame = 1'b1;
        cyc(1);
        bif.startOfFrame = 1'b0;
        if (pulse) begin
            e.col   = col;
            e.balls = balls;
            e.hole  = hole;
            e.due   = cycNum + 1;
            sbq.push_back(e);
        end
        cyc(3);
        checkVal("balls_after_frame", bif.balls_in_game, balls);
        checkVal("hole_after_frame", bif.curr_Hole_id, hole);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (monOn && bif.ballhole_collide != '0) begin
                if (sbq.size() == 0) begin
                    checkVal("spurious_pulse", bif.ballhole_collide, 0);
                end else begin
                    e = sbq.pop_front();
                    checkVal("collide", bif.ballhole_collide, e.col);
                    checkVal("balls_at_pulse", bif.balls_in_game, e.balls);
                    checkVal("hole_at_pulse", bif.curr_Hole_id, e.hole);
                    checkVal("pulse_cycle", cycNum, e.due);
                end
            end
        end
    end

    initial begin
        reset            = 1'b1;
        bif.startOfFrame = 1'b0;
        bif.ball_draw    = '0;
        bif.hole_draw    = 1'b0;
        bif.hole_id      = '0;
        bif.stage_num    = 4'd0;
        bif.request_hole = '0;
        cyc(2);
        checkVal("rst_balls", bif.balls_in_game, 3'b111);
        checkVal("rst_collide", bif.ballhole_collide, 3'b000);
        checkVal("rst_hole", bif.curr_Hole_id, 3'd0);
        reset = 1'b0;
        monOn = 1'b1;

        // Stage 0->1 re-rack; overlap during holdoff must not pocket.
        bif.stage_num = 4'd1;
        cyc(3);
        checkVal("rerack_balls", bif.balls_in_game, 3'b111);
        for (int f = 0; f < 4; f++) begin
            drawPixels(1, 30, 3'd3);
            endFrame(1'b0, 3'b000, 3'b111, 3'd0);
        end

        // 15 pixels twice: below threshold, and the count must not carry over.
        drawPixels(2, 15, 3'd5);
        endFrame(1'b0, 3'b000, 3'b111, 3'd0);
        drawPixels(2, 15, 3'd5);
        endFrame(1'b0, 3'b000, 3'b111, 3'd0);

        // Stage change on the same cycle as startOfFrame discards the evaluation.
        drawPixels(1, 30, 3'd3);
        bif.stage_num = 4'd2;
        endFrame(1'b0, 3'b000, 3'b111, 3'd0);
        for (int f = 0; f < 4; f++) begin
            drawPixels(1, 30, 3'd3);
            endFrame(1'b0, 3'b000, 3'b111, 3'd0);
        end

        // Pocket ball 1 on hole 3; later draws of ball 1 are ignored.
        drawPixels(1, 20, 3'd3);
        endFrame(1'b1, 3'b010, 3'b101, 3'd3);
        drawPixels(1, 30, 3'd2);
        endFrame(1'b0, 3'b000, 3'b101, 3'd3);

        // White ball at exactly the threshold, then respot after 3 frames.
        drawPixels(0, 16, 3'd6);
        endFrame(1'b1, 3'b001, 3'b100, 3'd6);
        drawPixels(0, 30, 3'd1);
        endFrame(1'b0, 3'b000, 3'b100, 3'd6);
        endFrame(1'b0, 3'b000, 3'b100, 3'd6);
        endFrame(1'b0, 3'b000, 3'b101, 3'd6);

        // Re-rack, then two balls pocketed in one frame.
        bif.stage_num = 4'd3;
        cyc(3);
        for (int f = 0; f < 4; f++) endFrame(1'b0, 3'b000, 3'b111, 3'd6);
        drawPixels(2, 20, 3'd5);
        drawPixels(1, 17, 3'd2);
        endFrame(1'b1, 3'b110, 3'b001, 3'd2);

        bif.stage_num    = 4'd4;
        bif.request_hole = 3'd4;
        cyc(3);
        for (int f = 0; f < 4; f++) endFrame(1'b0, 3'b000, 3'b111, 3'd2);
`ifdef POCKET_HOLE_FILTER_EN
        drawPixels(1, 30, 3'd1);
        endFrame(1'b0, 3'b000, 3'b111, 3'd2);
        drawPixels(1, 30, 3'd4);
        endFrame(1'b1, 3'b010, 3'b101, 3'd4);
`else
        drawPixels(1, 20, 3'd1);
        endFrame(1'b1, 3'b010, 3'b101, 3'd1);
`endif

        // Asynchronous reset mid-frame, between clock edges.
        drawPixels(2, 10, 3'd5);
        #2;
        reset = 1'b1;
        #1;
        checkVal("async_rst_balls", bif.balls_in_game, 3'b111);
        checkVal("async_rst_collide", bif.ballhole_collide, 3'b000);
        checkVal("async_rst_hole", bif.curr_Hole_id, 3'd0);
        bif.stage_num    = 4'd0;
        bif.request_hole = 3'd0;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        drawPixels(2, 10, 3'd5);
        endFrame(1'b0, 3'b000, 3'b111, 3'd0);

        cyc(4);
        checkVal("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
